// File: rtl/dac70004_spi_rx.sv
// dac70004_spi_rx: DAC70004 serial-port receiver model with per-channel buffer/output registers; `define DAC70004_RX_STRICT_SYNC_EN to abort frames whose SYNC rises before bit 32
module dac70004_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FCNT_W      = 16,
    parameter int ECNT_W      = 8
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic              i_dac_sclk,
    input  logic              i_dac_sync,
    input  logic              i_dac_sdin,
    output logic [31:0]       o_frame_data,
    output logic              o_frame_valid,
    output logic [3:0]        o_frame_cmd,
    output logic [3:0]        o_frame_addr,
    output logic [15:0]       o_frame_code,
    output logic [63:0]       o_ch_out,
    output logic [63:0]       o_ch_buf,
    output logic              o_rx_busy,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic [ECNT_W-1:0] o_err_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;
    state_t r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_s, r_sync_s, r_sdin_s;
    logic r_sclk_d, r_sync_d;
    logic [31:0] r_shreg, r_frame, w_frame;
    logic [4:0] r_bcnt;
    logic [3:0][15:0] r_buf, r_out, w_buf_nxt, w_out_nxt;
    logic [FCNT_W-1:0] r_fcnt;
    logic [ECNT_W-1:0] r_ecnt;
    logic w_sclk, w_sync, w_sdin, w_sclk_fall, w_sync_fall, w_shift, w_sample, w_last, w_lvl_abort, w_ok, w_err;
    logic [3:0] w_cmd, w_addr, w_sel;
    logic [15:0] w_code;
    assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
    assign w_sync      = r_sync_s[SYNC_STAGES-1];
    assign w_sdin      = r_sdin_s[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_d & ~w_sclk;
    assign w_sync_fall = r_sync_d & ~w_sync;
    assign w_shift     = r_state == SHIFT;
    // a SYNC re-fall beats a coincident SCLK edge, so that edge is never sampled
    assign w_sample    = w_shift & w_sclk_fall & ~w_sync_fall;
    assign w_last      = w_sample & (r_bcnt == 5'd31);
`ifdef DAC70004_RX_STRICT_SYNC_EN
    assign w_lvl_abort = w_shift & w_sync & ~w_last;
`else
    assign w_lvl_abort = 1'b0;
`endif
    assign w_frame = {r_shreg[30:0], w_sdin};
    assign w_cmd   = w_frame[27:24];
    assign w_addr  = w_frame[23:20];
    assign w_code  = w_frame[19:4];
    assign w_sel   = w_addr == 4'hF ? 4'hF : w_addr < 4'd4 ? 4'b0001 << w_addr[1:0] : 4'h0;
    assign w_ok    = (w_cmd[3:2] == 2'b00) && (|w_sel);
    assign w_err   = (w_shift & w_sync_fall) | w_lvl_abort | (w_last & ~w_ok);
    always_comb begin
        w_buf_nxt = r_buf;
        w_out_nxt = r_out;
        for (int c = 0; c < 4; c++) begin
            w_buf_nxt[c] = (w_ok && w_sel[c] && w_cmd != 4'h1) ? w_code : r_buf[c];
            w_out_nxt[c] = !w_ok ? r_out[c] : w_cmd == 4'h2 ? w_buf_nxt[c] : !w_sel[c] ? r_out[c] :
                           w_cmd == 4'h1 ? r_buf[c] : w_cmd == 4'h3 ? w_code : r_out[c];
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_sync_fall ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = w_lvl_abort ? IDLE : w_last ? DECODE : SHIFT;
            DECODE:  w_state_nxt = w_sync_fall ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_sclk_s <= '0;
            r_sync_s <= '1;
            r_sdin_s <= '0;
            r_sclk_d <= 1'b0;
            r_sync_d <= 1'b1;
            r_bcnt   <= '0;
            r_shreg  <= '0;
            r_frame  <= '0;
            r_buf    <= '0;
            r_out    <= '0;
            r_fcnt   <= '0;
            r_ecnt   <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], i_dac_sclk};
            r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], i_dac_sync};
            r_sdin_s <= {r_sdin_s[SYNC_STAGES-2:0], i_dac_sdin};
            r_sclk_d <= w_sclk;
            r_sync_d <= w_sync;
            if (w_sync_fall) r_bcnt <= '0;
            else if (w_sample) r_bcnt <= r_bcnt + 5'd1;
            if (w_sample) r_shreg <= w_frame;
            if (w_last) begin
                r_frame <= w_frame;
                r_buf   <= w_buf_nxt;
                r_out   <= w_out_nxt;
                r_fcnt  <= r_fcnt + 1'b1;
            end
            if (w_err && !(&r_ecnt)) r_ecnt <= r_ecnt + 1'b1;
        end
    end
    assign o_frame_data  = r_frame;
    assign o_frame_valid = r_state == DECODE;
    assign o_frame_cmd   = r_frame[27:24];
    assign o_frame_addr  = r_frame[23:20];
    assign o_frame_code  = r_frame[19:4];
    assign o_ch_out      = r_out;
    assign o_ch_buf      = r_buf;
    assign o_rx_busy     = w_shift;
    assign o_frame_cnt   = r_fcnt;
    assign o_err_cnt     = r_ecnt;
endmodule

// File: tb/tb_dac70004_spi_rx.sv
// tb_dac70004_spi_rx: directed frames against dac70004_spi_rx with hand-computed register/counter values
module tb_dac70004_spi_rx;
    logic clk = 1'b0, rst = 1'b1, sclk = 1'b1, sync = 1'b1, sdin = 1'b0;
    logic [31:0] frame_data;
    logic frame_valid, rx_busy;
    logic [3:0] frame_cmd, frame_addr;
    logic [15:0] frame_code, frame_cnt;
    logic [63:0] ch_out, ch_buf;
    logic [7:0] err_cnt;
    int total = 0, bad = 0, vcnt = 0, v0 = 0;
    always #5 clk = ~clk;
    dac70004_spi_rx dut (
        .i_clk_50m(clk), .i_rst(rst), .i_dac_sclk(sclk), .i_dac_sync(sync), .i_dac_sdin(sdin),
        .o_frame_data(frame_data), .o_frame_valid(frame_valid), .o_frame_cmd(frame_cmd),
        .o_frame_addr(frame_addr), .o_frame_code(frame_code), .o_ch_out(ch_out), .o_ch_buf(ch_buf),
        .o_rx_busy(rx_busy), .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt)
    );
    always @(negedge clk) if (frame_valid) vcnt++;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask
    task automatic wc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset;
        rst = 1'b1; sync = 1'b1; sclk = 1'b1; sdin = 1'b0;
        wc(4);
        rst = 1'b0;
        wc(4);
    endtask
    // mode 0 normal, 1 release SYNC after bit 1, 2 re-arm SYNC on the last bit, 3 leave SYNC low
    task automatic frame(input logic [31:0] d, input int nbits, input int half, input int mode);
        sync = 1'b0; sdin = d[31]; sclk = 1'b1;
        wc(half);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            if (mode == 2 && i == nbits - 1) begin
                sync = 1'b1;
                wc(1);
                return;
            end
            wc(half);
            sclk = 1'b1;
            if (mode == 1) sync = 1'b1;
            if (i < 31) sdin = d[30-i];
            wc(half);
        end
        if (mode != 3) sync = 1'b1;
        wc(8);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset;
        chk("rst_data", frame_data, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_out", ch_out, 0);
        chk("rst_buf", ch_buf, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);
        v0 = vcnt;
        frame(32'h030ABCD0, 32, 1, 0);
        chk("t1_valid", vcnt - v0, 1);
        chk("t1_out", ch_out, 64'h0000_0000_0000_ABCD);
        chk("t1_buf", ch_buf, 64'h0000_0000_0000_ABCD);
        chk("t1_fcnt", frame_cnt, 1);
        chk("t1_data", frame_data, 32'h030ABCD0);
        chk("t1_fields", {frame_cmd, frame_addr, frame_code}, 24'h30ABCD);
        chk("t1_busy", rx_busy, 0);
        frame(32'h03155550, 10, 1, 3);
        chk("mid_busy", rx_busy, 1);
        rst = 1'b1; sync = 1'b1; sclk = 1'b1;
        wc(2);
        chk("mid_rst_busy", rx_busy, 0);
        rst = 1'b0;
        wc(4);
        chk("mid_out", ch_out, 0);
        chk("mid_fcnt", frame_cnt, 0);
        frame(32'h00F12340, 32, 2, 0);
        frame(32'h01200000, 32, 2, 0);
        chk("t2_buf", ch_buf, 64'h1234_1234_1234_1234);
        chk("t2_out", ch_out, 64'h0000_1234_0000_0000);
        chk("t2_fcnt", frame_cnt, 2);
        chk("t2_ecnt", err_cnt, 0);
        do_reset;
        v0 = vcnt;
        frame(32'hFFFFFFFF, 10, 1, 0);
        frame(32'h03155550, 32, 1, 0);
        chk("t3_ecnt", err_cnt, 1);
        chk("t3_out", ch_out, 64'h0000_0000_5555_0000);
        chk("t3_fcnt", frame_cnt, 1);
        chk("t3_valid", vcnt - v0, 1);
        v0 = vcnt;
        for (int i = 0; i < 200; i++) begin
            sclk = ~sclk;
            wc(1);
        end
        wc(4);
        chk("t4_valid", vcnt - v0, 0);
        chk("t4_busy", rx_busy, 0);
        chk("t4_cnts", {frame_cnt, err_cnt}, {16'd1, 8'd1});
        v0 = vcnt;
        frame(32'h07055550, 32, 1, 0);
        chk("t5_valid", vcnt - v0, 1);
        chk("t5_ecnt", err_cnt, 2);
        chk("t5_fcnt", frame_cnt, 2);
        chk("t5_cmd", frame_cmd, 4'h7);
        frame(32'h03512340, 32, 1, 0);
        chk("t5_addr", {frame_addr, frame_code}, 20'h51234);
        chk("t5_ecnt2", err_cnt, 3);
        chk("t5_out", ch_out, 64'h0000_0000_5555_0000);
        chk("t5_buf", ch_buf, 64'h0000_0000_5555_0000);
        do_reset;
        frame(32'h00011110, 32, 1, 0);
        frame(32'h02322220, 32, 1, 0);
        chk("t6_buf", ch_buf, 64'h2222_0000_0000_1111);
        chk("t6_out", ch_out, 64'h2222_0000_0000_1111);
        do_reset;
        v0 = vcnt;
        frame(32'h03200070, 32, 2, 1);
`ifdef DAC70004_RX_STRICT_SYNC_EN
        chk("t7_valid", vcnt - v0, 0);
        chk("t7_ecnt", err_cnt, 1);
        chk("t7_fcnt", frame_cnt, 0);
        chk("t7_out", ch_out, 0);
`else
        chk("t7_valid", vcnt - v0, 1);
        chk("t7_ecnt", err_cnt, 0);
        chk("t7_fcnt", frame_cnt, 1);
        chk("t7_out", ch_out, 64'h0000_0007_0000_0000);
`endif
        do_reset;
        v0 = vcnt;
        frame(32'h03000010, 32, 1, 2);
        frame(32'h03100020, 32, 1, 0);
        chk("t8_valid", vcnt - v0, 2);
        chk("t8_fcnt", frame_cnt, 2);
        chk("t8_out", ch_out, 64'h0000_0000_0002_0001);
        chk("t8_ecnt", err_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
